// File: rtl/mat_seq_pkg.sv
// mat_seq_pkg
// Shared definitions for the matrix-multiply sequencer: default sizes,
// the sequencer state encoding and the dimension legality check.
package mat_seq_pkg;

  localparam int DIM_MAX  = 16;
  localparam int IDX_BITS = 4;
  localparam int DATA_W   = 32;
  localparam int DIM_BITS = IDX_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // True when A (h_a x w_a) times B (h_b x w_b) is a legal product that
  // fits the buffers.
  function automatic logic dims_ok(input logic [DIM_BITS-1:0] wa,
                                   input logic [DIM_BITS-1:0] ha,
                                   input logic [DIM_BITS-1:0] wb,
                                   input logic [DIM_BITS-1:0] hb);
    logic [DIM_BITS-1:0] lim;
    lim = DIM_BITS'(DIM_MAX);
    return (wa == hb) &&
           (wa != '0) && (ha != '0) && (wb != '0) && (hb != '0) &&
           (wa <= lim) && (ha <= lim) && (wb <= lim) && (hb <= lim);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// mac_unit
// Single multiply-accumulate lane. Multiplies two's complement operands,
// keeps the low W bits of the product and accumulates modulo 2^W.
// Ports:
//   i_clk, i_rst  clock, async active-high reset
//   i_clr         zero the accumulator (wins over i_en)
//   i_en          add i_a*i_b to the accumulator
//   i_a, i_b      operands
//   o_acc         registered accumulator value
module mac_unit #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_acc
);

  logic [W-1:0] w_prod;
  logic [W-1:0] r_acc;

  // Only the low W bits of the product are kept; those bits are identical
  // for a signed and an unsigned multiply, so a W-bit multiply suffices.
  assign w_prod = i_a * i_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mat_mul_sequencer.sv
// mat_mul_sequencer
// Walks every C[i][j] of C = A x B, streaming A[i][k]/B[k][j] from the
// operand buffers into one MAC and writing each finished sum to C.
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   start, abort              one-cycle go request / return to idle
//   w_a, h_a, w_b, h_b        dimensions, sampled on an accepted start
//   a_rd_*, b_rd_*            operand read strobes, addresses, data (1-cycle latency)
//   c_wr_*                    result write strobe, address, data
//   busy, done, err           status: running, completion pulse, sticky dim error
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | validate the sampled dimensions
// CLEAR  | zero accumulator, k = 0, launch first read
// RUN    | one operand read per cycle, accumulate previous product
// DRAIN  | accumulate last product
// WRITE  | C[i][j] strobe, advance j/i
// FINISH | done pulse
module mat_mul_sequencer
  import mat_seq_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_BITS-1:0] w_a,
  input  logic [DIM_BITS-1:0] h_a,
  input  logic [DIM_BITS-1:0] w_b,
  input  logic [DIM_BITS-1:0] h_b,
  output logic                a_rd_en,
  output logic                b_rd_en,
  output logic [IDX_BITS-1:0] a_rd_row,
  output logic [IDX_BITS-1:0] a_rd_col,
  output logic [IDX_BITS-1:0] b_rd_row,
  output logic [IDX_BITS-1:0] b_rd_col,
  input  logic [DATA_W-1:0]   a_rd_data,
  input  logic [DATA_W-1:0]   b_rd_data,
  output logic                c_wr_en,
  output logic [IDX_BITS-1:0] c_wr_row,
  output logic [IDX_BITS-1:0] c_wr_col,
  output logic [DATA_W-1:0]   c_wr_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_t              r_state;
  logic [DIM_BITS-1:0] r_w_a, r_h_a, r_w_b, r_h_b;
  logic [IDX_BITS-1:0] r_i, r_j, r_k;
  logic                r_rd_en;
  logic [IDX_BITS-1:0] r_a_rd_row, r_a_rd_col, r_b_rd_row, r_b_rd_col;
  logic                r_c_wr_en;
  logic [IDX_BITS-1:0] r_c_wr_row, r_c_wr_col;
  logic                r_busy, r_done, r_err;

  logic                w_k_last, w_j_last, w_i_last;
  logic                w_mac_clr, w_mac_en;
  logic [DATA_W-1:0]   w_acc;

  assign w_k_last = ({1'b0, r_k} == (r_w_a - 1'b1));
  assign w_j_last = ({1'b0, r_j} == (r_w_b - 1'b1));
  assign w_i_last = ({1'b0, r_i} == (r_h_a - 1'b1));

  // Read data lags its strobe by one cycle, so the first RUN cycle has
  // nothing to add yet and DRAIN picks up the final operand pair.
  assign w_mac_clr = (r_state == ST_CLEAR);
  assign w_mac_en  = ((r_state == ST_RUN) && (r_k != '0)) || (r_state == ST_DRAIN);

  mac_unit #(.W(DATA_W)) u_mac (
    .i_clk (wb_clk_i),
    .i_rst (wb_rst_i),
    .i_clr (w_mac_clr),
    .i_en  (w_mac_en),
    .i_a   (a_rd_data),
    .i_b   (b_rd_data),
    .o_acc (w_acc)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_w_a      <= '0;
      r_h_a      <= '0;
      r_w_b      <= '0;
      r_h_b      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_rd_en    <= 1'b0;
      r_a_rd_row <= '0;
      r_a_rd_col <= '0;
      r_b_rd_row <= '0;
      r_b_rd_col <= '0;
      r_c_wr_en  <= 1'b0;
      r_c_wr_row <= '0;
      r_c_wr_col <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state   <= ST_IDLE;
      r_rd_en   <= 1'b0;
      r_c_wr_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && !abort) begin
            r_w_a   <= w_a;
            r_h_a   <= h_a;
            r_w_b   <= w_b;
            r_h_b   <= h_b;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!dims_ok(r_w_a, r_h_a, r_w_b, r_h_b)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_i     <= '0;
            r_j     <= '0;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_k        <= '0;
          r_rd_en    <= 1'b1;
          r_a_rd_row <= r_i;
          r_a_rd_col <= '0;
          r_b_rd_row <= '0;
          r_b_rd_col <= r_j;
          r_state    <= ST_RUN;
        end
        ST_RUN: begin
          if (w_k_last) begin
            r_rd_en <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_k        <= r_k + 1'b1;
            r_a_rd_col <= r_k + 1'b1;
            r_b_rd_row <= r_k + 1'b1;
          end
        end
        ST_DRAIN: begin
          r_c_wr_en  <= 1'b1;
          r_c_wr_row <= r_i;
          r_c_wr_col <= r_j;
          r_state    <= ST_WRITE;
        end
        ST_WRITE: begin
          r_c_wr_en <= 1'b0;
          if (w_j_last) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
          if (w_i_last && w_j_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FINISH;
          end else begin
            r_state <= ST_CLEAR;
          end
        end
        ST_FINISH: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_rd_en   = r_rd_en;
  assign b_rd_en   = r_rd_en;
  assign a_rd_row  = r_a_rd_row;
  assign a_rd_col  = r_a_rd_col;
  assign b_rd_row  = r_b_rd_row;
  assign b_rd_col  = r_b_rd_col;
  assign c_wr_en   = r_c_wr_en;
  assign c_wr_row  = r_c_wr_row;
  assign c_wr_col  = r_c_wr_col;
  // The accumulator is itself a register and holds the finished sum
  // throughout WRITE.
  assign c_wr_data = w_acc;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule
